umw_frame_serializer: RTL
=========================

// Module: umw_frame_serializer
// PURPOSE
// - Downstream consumer of the umwkebxpy-style output array, a bit [0:2] x3 element frame.
// - Captures whole 3-element frames with a valid/ready handshake.
// - Buffers up to DEPTH frames.
// - Emits the frames one element per beat on a serial valid/ready stream, in ascending index order.
// - Adds per-element parity and a last-element marker.
// PARAMETERS
// - ELEM_W  3  bits per element (packed [0:ELEM_W-1])
// - N_ELEM  3  elements per frame (unpacked [0:N_ELEM-1]); must be >= 2
// - DEPTH   4  frame FIFO depth; power of two, >= 2
// PORTS
// - clk        in   1                 single clock; all state updates on posedge
// - rst        in   1                 synchronous, active-high reset
// - cap_valid  in   1                 producer offers cap_data this cycle
// - cap_ready  out  1                 frame FIFO can accept (= !full)
// - cap_data   in   [0:ELEM_W-1] x [0:N_ELEM-1]  frame; element 0 sent first
// - out_valid  out  1                 out_* fields hold a valid element
// - out_ready  in   1                 consumer accepts element this cycle
// - out_data   out  ELEM_W            current element
// - out_idx    out  $clog2(N_ELEM)    index of current element within its frame
// - out_last   out  1                 high when out_idx == N_ELEM-1
// - out_par    out  1                 XOR-reduce of out_data
// - level      out  $clog2(DEPTH)+1   frames held in FIFO (excludes frame in serializer)
// - stall_seen out  1                 sticky: cap_valid seen while cap_ready low
// BEHAVIOUR
// - Reset values:
//   - cap_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, out_par=0.
//   - level=0, stall_seen=0, FSM=IDLE.
//   - FIFO pointers cleared.
// - Reset mid-operation discards all buffered frames and any partially sent frame. No element is re-emitted after reset.
// - Capture:
//   - A push occurs on cap_valid && cap_ready.
//   - cap_ready depends only on registered state: no combinational path from out_ready.
//   - A full FIFO deasserts cap_ready even if a pop happens in the same cycle.
// - FIFO: first-word-fall-through frames. Simultaneous push and pop keep level unchanged. The write pointer wraps modulo DEPTH.
// - FSM states:
//   - IDLE: out_valid=0. If the FIFO is non-empty, pop its head into the shift register and go to SEND with idx=0.
//   - SEND:
//     - out_valid=1; out_data = frame[idx].
//     - On out_ready, advance idx.
//     - At idx == N_ELEM-1 with out_ready:
//       - If the FIFO is non-empty, pop the next frame and stay in SEND with idx=0 (back-to-back, no bubble).
//       - Otherwise go to IDLE.
// - Latency: first element is valid 2 cycles after the capturing edge (push edge, then load edge).
// - Steady-state throughput: 1 element per cycle while out_ready=1.
// - out_data, out_idx, out_last and out_par are held stable while out_valid && !out_ready.
// - out_par is registered with out_data, so there is never a combinational mismatch.
// - stall_seen is set on any cycle with cap_valid && !cap_ready. It is cleared only by rst.
// - level counts frames held in the FIFO, saturating at DEPTH. It never underflows, because a pop is gated by !empty.
// STRUCTURE
// - Package umw_pkg:
//   - ELEM_W and N_ELEM defaults.
//   - typedef elem_t = bit [0:ELEM_W-1].
//   - typedef frame_t = elem_t [0:N_ELEM-1].
//   - enum ser_state_e {IDLE, SEND}.
// - Sub-module umw_frame_fifo:
//   - Parameterised by DEPTH, holding frame_t entries.
//   - push/pop/full/empty/level interface with a registered full flag.
// - Top level contains the FSM, the element mux, the parity and the stall flag.
// TESTING
// - Single frame: push {3'b101,3'b011,3'b110} with out_ready=1.
//   - out_data is 101,011,110 on 3 consecutive cycles.
//   - out_idx is 0,1,2 and out_last is high only on 110.
//   - out_par is 0,0,0.
// - Backpressure: hold out_ready=0 for 5 cycles on element 1.
//   - out_data stays 011 and out_idx stays 1.
//   - Element 2 follows the cycle after out_ready rises.
// - Full: push 5 frames with out_ready=0.
//   - cap_ready drops after the frame that fills the FIFO; level reads 4.
//   - stall_seen=1 when the 6th cap_valid is held.
// - Back-to-back: 2 frames queued, out_ready=1.
//   - Emits 6 contiguous valid beats with no bubble.
//   - out_idx sequence 0,1,2,0,1,2.
// - Simultaneous push/pop with level=2: level stays 2 and the frame order is preserved.
// - Reset at idx=1 of a frame with level=3:
//   - Next cycle out_valid=0, level=0, stall_seen=0.
//   - The next pushed frame is emitted from idx 0.

Source files
------------

// File: rtl/umw_pkg.sv
// Shared element/frame types and FSM state encoding for the frame serializer.
package umw_pkg;

    localparam int unsigned ELEM_W = 3;
    localparam int unsigned N_ELEM = 3;
    localparam int unsigned DEPTH  = 4;

    typedef logic [0:ELEM_W-1] elem_t;
    typedef elem_t [0:N_ELEM-1] frame_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_e;

endpackage

// File: rtl/umw_frame_fifo.sv
// First-word-fall-through frame FIFO with a registered full flag.
module umw_frame_fifo import umw_pkg::*; #(
    parameter int unsigned DEPTH   = umw_pkg::DEPTH,
    parameter type         entry_t = frame_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_n;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        level_n = level;
        unique case ({do_push, do_pop})
            2'b10:   level_n = level + LVL_W'(1);
            2'b01:   level_n = level - LVL_W'(1);
            default: level_n = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // full is registered from the next level, so it never sees a same-cycle pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_n;
            full  <= (level_n == LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/umw_frame_serializer.sv
// Buffers whole frames and streams them out one element per beat with parity and last marker.
module umw_frame_serializer import umw_pkg::*; #(
    parameter int unsigned ELEM_W = umw_pkg::ELEM_W,
    parameter int unsigned N_ELEM = umw_pkg::N_ELEM,
    parameter int unsigned DEPTH  = umw_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cap_valid,
    output logic                        cap_ready,
    input  logic [0:ELEM_W-1]           cap_data [0:N_ELEM-1],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [0:ELEM_W-1]           out_data,
    output logic [$clog2(N_ELEM)-1:0]   out_idx,
    output logic                        out_last,
    output logic                        out_par,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        stall_seen
);

    localparam int unsigned IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef logic [0:ELEM_W-1] elem_lt;
    typedef elem_lt [0:N_ELEM-1] frame_lt;

    ser_state_e         state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    frame_lt            frame_q, frame_n;
    frame_lt            cap_frame;
    frame_lt            head;
    elem_lt             elem_n;
    logic               pop;
    logic               full;
    logic               empty;

    always_comb begin
        cap_frame = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            cap_frame[i] = cap_data[i];
        end
    end

    assign cap_ready = !full;

    umw_frame_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (frame_lt)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_valid),
        .wdata (cap_frame),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        frame_n = frame_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    frame_n = head;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_n = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            frame_n = head;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output element is selected from next-state values so data and parity register together
    always_comb begin
        elem_n = '0;
        if (state_n == SEND) begin
            elem_n = frame_n[idx_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            out_data   <= '0;
            out_par    <= 1'b0;
            out_last   <= 1'b0;
            stall_seen <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            frame_q  <= frame_n;
            out_data <= elem_n;
            out_par  <= ^elem_n;
            out_last <= (state_n == SEND) && (idx_n == LAST_IDX);
            if (cap_valid && !cap_ready) begin
                stall_seen <= 1'b1;
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_idx   = idx_q;

endmodule
